// File: rtl/instr_defs.sv
// Mnemonic codes and MIPS op/funct constants shared by the encoder and the
// pipeline's control decoder.
package instr_defs;

    typedef enum logic [4:0] {
        MN_NOP  = 5'd0,
        MN_ADD  = 5'd1,
        MN_ADDU = 5'd2,
        MN_SUB  = 5'd3,
        MN_SUBU = 5'd4,
        MN_AND  = 5'd5,
        MN_OR   = 5'd6,
        MN_SLT  = 5'd7,
        MN_SLTU = 5'd8,
        MN_JR   = 5'd9,
        MN_LW   = 5'd10,
        MN_LB   = 5'd11,
        MN_SW   = 5'd12,
        MN_BEQ  = 5'd13,
        MN_ANDI = 5'd14,
        MN_ADDI = 5'd15,
        MN_ORI  = 5'd16,
        MN_LUI  = 5'd17,
        MN_J    = 5'd18,
        MN_JAL  = 5'd19
    } mnem_e;

    localparam logic [4:0] MNEM_LAST = 5'd19;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

endpackage

// File: rtl/enc_skid.sv
// Two-entry valid/ready buffer: output register plus one skid entry.
// in_ready comes straight from a flop, so out_ready never reaches it combinationally.
module enc_skid
    import instr_defs::*;
#(
    parameter int            W        = 65,
    parameter logic [W-1:0]  RST_DATA = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         r_out_vld;
    logic [W-1:0] r_out_data;
    logic         r_skid_vld;
    logic [W-1:0] r_skid_data;
    logic         w_acc;
    logic         w_load;

    assign in_ready  = !r_skid_vld;
    assign out_valid = r_out_vld;
    assign out_data  = r_out_data;
    assign w_acc     = in_valid && !r_skid_vld;
    assign w_load    = !r_out_vld || out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_out_vld   <= 1'b0;
            r_out_data  <= RST_DATA;
            r_skid_vld  <= 1'b0;
            r_skid_data <= RST_DATA;
        end else if (w_load) begin
            // Skid is older than anything arriving now, so it drains first.
            if (r_skid_vld) begin
                r_out_data <= r_skid_data;
                r_out_vld  <= 1'b1;
                r_skid_vld <= 1'b0;
            end else if (w_acc) begin
                r_out_data <= in_data;
                r_out_vld  <= 1'b1;
            end else begin
                r_out_vld  <= 1'b0;
            end
        end else if (w_acc) begin
            r_skid_data <= in_data;
            r_skid_vld  <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Mnemonic-plus-fields to MIPS word encoder with sequential address tagging
// and a skid-buffered output stage.
module instr_encoder
    import instr_defs::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int          ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_mnem,
    input  logic [4:0]           in_rs,
    input  logic [4:0]           in_rt,
    input  logic [4:0]           in_rd,
    input  logic [15:0]          in_imm,
    input  logic [25:0]          in_target,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_word,
    output logic [31:0]          out_addr,
    output logic                 out_illegal,
    output logic [ILL_CNT_W-1:0] ill_count
);

    localparam int DW = 65;

    logic [31:0]          r_addr;
    logic [ILL_CNT_W-1:0] r_ill_cnt;
    logic [31:0]          w_word;
    logic                 w_ill;
    logic                 w_acc;
    logic                 w_in_ready;
    logic [DW-1:0]        w_out_data;

    always_comb begin
        w_word = '0;
        w_ill  = 1'b0;
        case (in_mnem)
            MN_NOP:  w_word = '0;
            MN_ADD:  w_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_ADD};
            MN_ADDU: w_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_ADDU};
            MN_SUB:  w_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_SUB};
            MN_SUBU: w_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_SUBU};
            MN_AND:  w_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_AND};
            MN_OR:   w_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_OR};
            MN_SLT:  w_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_SLT};
            MN_SLTU: w_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'd0, FN_SLTU};
            MN_JR:   w_word = {OP_RTYPE, in_rs, 5'd0, 5'd0, 5'd0, FN_JR};
            MN_LW:   w_word = {OP_LW,   in_rs, in_rt, in_imm};
            MN_LB:   w_word = {OP_LB,   in_rs, in_rt, in_imm};
            MN_SW:   w_word = {OP_SW,   in_rs, in_rt, in_imm};
            MN_BEQ:  w_word = {OP_BEQ,  in_rs, in_rt, in_imm};
            MN_ANDI: w_word = {OP_ANDI, in_rs, in_rt, in_imm};
            MN_ADDI: w_word = {OP_ADDI, in_rs, in_rt, in_imm};
            MN_ORI:  w_word = {OP_ORI,  in_rs, in_rt, in_imm};
            MN_LUI:  w_word = {OP_LUI,  5'd0,  in_rt, in_imm};
            MN_J:    w_word = {OP_J,    in_target};
            MN_JAL:  w_word = {OP_JAL,  in_target};
            default: w_ill  = (in_mnem > MNEM_LAST);
        endcase
    end

    // A request in the flush cycle is dropped, so it must not consume an address.
    assign w_acc    = in_valid && w_in_ready && !flush;
    assign in_ready = w_in_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_addr <= BASE_ADDR;
        end else if (w_acc) begin
            r_addr <= r_addr + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ill_cnt <= '0;
        end else if (w_acc && w_ill && (r_ill_cnt != '1)) begin
            r_ill_cnt <= r_ill_cnt + 1'b1;
        end
    end

    assign ill_count = r_ill_cnt;

    enc_skid #(
        .W        (DW),
        .RST_DATA ({32'h0, BASE_ADDR, 1'b0})
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid && !flush),
        .in_ready  (w_in_ready),
        .in_data   ({w_word, r_addr, w_ill}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_data)
    );

    assign out_word    = w_out_data[64:33];
    assign out_addr    = w_out_data[32:1];
    assign out_illegal = w_out_data[0];

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, back-pressure, illegal counting,
// flush/reset and address wrap (second instance with a high base).
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [4:0]  in_mnem, in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_word, out_addr;
    logic [7:0]  ill_count;

    logic        b_reset, b_valid, b_ready, b_in_ready, b_out_valid, b_out_ill;
    logic [31:0] b_word, b_addr;
    logic [7:0]  b_ill_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_addr(out_addr),
        .out_illegal(out_illegal), .ill_count(ill_count)
    );

    instr_encoder #(.BASE_ADDR(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(b_reset), .flush(1'b0),
        .in_valid(b_valid), .in_ready(b_in_ready),
        .in_mnem(5'd16), .in_rs(5'd0), .in_rt(5'd1), .in_rd(5'd0),
        .in_imm(16'h0001), .in_target(26'd0),
        .out_valid(b_out_valid), .out_ready(b_ready),
        .out_word(b_word), .out_addr(b_addr),
        .out_illegal(b_out_ill), .ill_count(b_ill_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tg);
        in_valid = 1'b1; in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd;
        in_imm = imm; in_target = tg;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ovld"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_word"}, out_word, 32'd0);
        chk({tag, "_addr"}, out_addr, 32'h3000);
        chk({tag, "_ill"},  {31'd0, out_illegal}, 32'd0);
        chk({tag, "_irdy"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_icnt"}, {24'd0, ill_count}, 32'd0);
    endtask

    initial begin
        flush = 0; out_ready = 1; b_reset = 1; b_valid = 0; b_ready = 1;
        req(5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0); in_valid = 0;
        do_reset();
        b_reset = 0;
        chk_reset_state("rst");

        // Single ori
        req(5'd16, 5'd0, 5'd1, 5'd0, 16'h1234, 26'd0); tick();
        chk("ori_word", out_word, 32'h3401_1234);
        chk("ori_addr", out_addr, 32'h3000);
        chk("ori_vld",  {31'd0, out_valid}, 32'd1);
        chk("ori_ill",  {31'd0, out_illegal}, 32'd0);
        in_valid = 0;

        // Back-to-back with simultaneous accept and transfer; unused fields nonzero
        do_reset();
        req(5'd2, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'h3FF_FFFF); tick();
        chk("addu_word", out_word, 32'h0022_1821);
        chk("addu_addr", out_addr, 32'h3000);
        req(5'd10, 5'd0, 5'd4, 5'd7, 16'h0008, 26'h155_5555); tick();
        chk("lw_word", out_word, 32'h8C04_0008);
        chk("lw_addr", out_addr, 32'h3004);
        chk("lw_vld",  {31'd0, out_valid}, 32'd1);
        req(5'd9, 5'd31, 5'd5, 5'd6, 16'h1234, 26'd0); tick();
        chk("jr_word", out_word, 32'h03E0_0008);
        chk("jr_addr", out_addr, 32'h3008);
        in_valid = 0; tick();
        chk("drain_vld", {31'd0, out_valid}, 32'd0);

        // lui forces rs to zero
        req(5'd17, 5'd9, 5'd2, 5'd0, 16'hABCD, 26'd0); tick();
        chk("lui_word", out_word, 32'h3C02_ABCD);
        in_valid = 0;

        // Back-pressure into skid
        do_reset();
        out_ready = 0;
        req(5'd13, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'd0); tick();
        chk("bp1_irdy", {31'd0, in_ready}, 32'd1);
        chk("bp1_word", out_word, 32'h1022_FFFF);
        req(5'd19, 5'd0, 5'd0, 5'd0, 16'd0, 26'h000_0C00); tick();
        chk("bp2_irdy", {31'd0, in_ready}, 32'd0);
        in_valid = 0; tick();
        chk("bp_stable_word", out_word, 32'h1022_FFFF);
        chk("bp_stable_addr", out_addr, 32'h3000);
        out_ready = 1; tick();
        chk("bp_jal_word", out_word, 32'h0C00_0C00);
        chk("bp_jal_addr", out_addr, 32'h3004);
        chk("bp_irdy_back", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Illegal mnemonic, then saturation
        do_reset();
        req(5'd25, 5'd7, 5'd8, 5'd9, 16'hBEEF, 26'h3FF_FFFF); tick();
        chk("ill_word", out_word, 32'd0);
        chk("ill_flag", {31'd0, out_illegal}, 32'd1);
        chk("ill_cnt1", {24'd0, ill_count}, 32'd1);
        chk("ill_addr0", out_addr, 32'h3000);
        tick();
        chk("ill_addr1", out_addr, 32'h3004);
        for (int i = 0; i < 298; i++) tick();
        chk("ill_sat", {24'd0, ill_count}, 32'd255);
        tick();
        chk("ill_sat_hold", {24'd0, ill_count}, 32'd255);
        in_valid = 0; tick();

        // Flush with both entries full
        out_ready = 0;
        req(5'd2, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0); tick();
        req(5'd10, 5'd0, 5'd4, 5'd0, 16'h0008, 26'd0); tick();
        chk("fl_full", {31'd0, in_ready}, 32'd0);
        flush = 1;
        req(5'd16, 5'd0, 5'd1, 5'd0, 16'h1234, 26'd0); tick();
        flush = 0; in_valid = 0;
        chk("fl_ovld", {31'd0, out_valid}, 32'd0);
        chk("fl_irdy", {31'd0, in_ready}, 32'd1);
        chk("fl_icnt", {24'd0, ill_count}, 32'd255);
        chk("fl_addr", out_addr, 32'h3000);
        out_ready = 1;
        req(5'd16, 5'd0, 5'd1, 5'd0, 16'h1234, 26'd0); tick();
        chk("fl_next_word", out_word, 32'h3401_1234);
        chk("fl_next_addr", out_addr, 32'h3000);
        in_valid = 0;

        // Reset mid-stream with words buffered
        out_ready = 0;
        req(5'd1, 5'd1, 5'd1, 5'd1, 16'd0, 26'd0); tick();
        req(5'd18, 5'd0, 5'd0, 5'd0, 16'd0, 26'h123_4567); tick();
        reset = 1; in_valid = 0; tick();
        reset = 0; out_ready = 1;
        chk_reset_state("mid");
        tick();
        chk("mid_no_emit", {31'd0, out_valid}, 32'd0);

        // Address wrap on the high-base instance
        b_valid = 1; tick();
        chk("wrap0", b_addr, 32'hFFFF_FFF8);
        tick();
        chk("wrap1", b_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap2", b_addr, 32'h0000_0000);
        chk("wrap_word", b_word, 32'h3401_0001);
        b_valid = 0; tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
